// File: rtl/pacman_pkg.sv
// Shared types and scoring constants for the pacman score keeper.
// Score constants are BCD-encoded so they feed the BCD adder directly.
package pacman_pkg;

  localparam int unsigned SCORE_W     = 24;
  localparam int unsigned DYING_TICKS = 120;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_FRIGHT,
    ST_DYING,
    ST_OVER
  } state_t;

  localparam logic [SCORE_W-1:0] PTS_PELLET = 24'h000010;
  localparam logic [SCORE_W-1:0] PTS_POWER  = 24'h000050;
  // Dot and power pellet on the same cycle; no digit carry, so a single constant.
  localparam logic [SCORE_W-1:0] PTS_BOTH   = 24'h000060;
  localparam logic [SCORE_W-1:0] PTS_GHOST0 = 24'h000200;
  localparam logic [SCORE_W-1:0] PTS_GHOST1 = 24'h000400;
  localparam logic [SCORE_W-1:0] PTS_GHOST2 = 24'h000800;
  localparam logic [SCORE_W-1:0] PTS_GHOST3 = 24'h001600;
  localparam logic [SCORE_W-1:0] SCORE_CAP  = 24'h999990;

  // Ghost award for a multiplier index 0..3.
  function automatic logic [SCORE_W-1:0] ghost_pts(input logic [1:0] idx);
    case (idx)
      2'd0:    return PTS_GHOST0;
      2'd1:    return PTS_GHOST1;
      2'd2:    return PTS_GHOST2;
      default: return PTS_GHOST3;
    endcase
  endfunction

endpackage

// File: rtl/bcd_add6.sv
// Six-digit combinational BCD adder.
// Ports: a, b - BCD operands; sum - BCD result; carry - decimal overflow out of digit 5.
module bcd_add6
  import pacman_pkg::*;
(
  input  logic [SCORE_W-1:0] a,
  input  logic [SCORE_W-1:0] b,
  output logic [SCORE_W-1:0] sum,
  output logic               carry
);

  logic [4:0] d;
  logic       c;

  // Ripple digit by digit, applying the +6 decimal correction above 9.
  always_comb begin
    c   = 1'b0;
    d   = '0;
    sum = '0;
    for (int i = 0; i < 6; i++) begin
      d = 5'(a[i*4 +: 4]) + 5'(b[i*4 +: 4]) + 5'(c);
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      sum[i*4 +: 4] = d[3:0];
    end
    carry = c;
  end

endmodule

// File: rtl/score_keeper.sv
// Game score, lives, pellet count and frightened-mode timing for one player.
// Ports: clk/rst (sync, active-high); start; pellet_eaten, power_eaten,
// ghost_eaten[3:0] (bit 0 blinky), pacman_caught pulses from the maze;
// score_bcd (6 BCD digits), frightened, fright_flash, pellets_left, lives,
// level_clear (1-cycle pulse), game_over.
module score_keeper
  import pacman_pkg::*;
#(
  parameter int unsigned TOTAL_PELLETS = 244,
  parameter int unsigned FRIGHT_TICKS  = 360,
  parameter int unsigned FLASH_TICKS   = 120,
  parameter int unsigned START_LIVES   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pellet_eaten,
  input  logic               power_eaten,
  input  logic [3:0]         ghost_eaten,
  input  logic               pacman_caught,
  output logic [SCORE_W-1:0] score_bcd,
  output logic               frightened,
  output logic               fright_flash,
  output logic [7:0]         pellets_left,
  output logic [1:0]         lives,
  output logic               level_clear,
  output logic               game_over
);

  localparam int unsigned FW = $clog2(FRIGHT_TICKS + 1);
  localparam int unsigned DW = $clog2(DYING_TICKS + 1);
  localparam logic FLASH_AT_LOAD = 1'(FRIGHT_TICKS <= FLASH_TICKS);

  state_t             state;
  logic [FW-1:0]      fright_cnt;
  logic [DW-1:0]      dying_cnt;
  logic [1:0]         mult_idx;
  logic [3:0]         pending;

  logic               active;
  logic               pe;
  logic               pw;
  logic [3:0]         credit;
  logic [SCORE_W-1:0] pellet_add;
  logic [SCORE_W-1:0] ghost_add;
  logic [SCORE_W-1:0] addend;
  logic [SCORE_W-1:0] sum;
  logic               carry;
  logic [SCORE_W-1:0] score_nxt;
  logic [7:0]         dec;
  logic [7:0]         pellets_nxt;

  // Per-cycle score addend and pellet count; the level_clear cycle is a reload cycle.
  always_comb begin
    active     = ((state == ST_PLAY) || (state == ST_FRIGHT)) && !level_clear;
    pe         = pellet_eaten & active;
    pw         = power_eaten & active;
    credit     = pending & (~pending + 4'd1);
    pellet_add = '0;
    case ({pe, pw})
      2'b11:   pellet_add = PTS_BOTH;
      2'b10:   pellet_add = PTS_PELLET;
      2'b01:   pellet_add = PTS_POWER;
      default: pellet_add = '0;
    endcase
    ghost_add   = (|pending) ? ghost_pts(mult_idx) : '0;
    // Pellet points only touch the tens digit, ghost points only hundreds/thousands.
    addend      = pellet_add | ghost_add;
    dec         = 8'(pe) + 8'(pw);
    pellets_nxt = (pellets_left > dec) ? (pellets_left - dec) : '0;
  end

  bcd_add6 u_add (
    .a     (score_bcd),
    .b     (addend),
    .sum   (sum),
    .carry (carry)
  );

  // The LSB digit is always 0, so any overflow shows up as a decimal carry.
  assign score_nxt = carry ? SCORE_CAP : sum;

  // Game FSM with all counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      score_bcd    <= '0;
      lives        <= 2'(START_LIVES);
      pellets_left <= 8'(TOTAL_PELLETS);
      frightened   <= 1'b0;
      fright_flash <= 1'b0;
      level_clear  <= 1'b0;
      game_over    <= 1'b0;
      fright_cnt   <= '0;
      dying_cnt    <= '0;
      mult_idx     <= '0;
      pending      <= '0;
    end else begin
      score_bcd    <= score_nxt;
      // Ghosts are only latched while frightened, but drain regardless of state.
      pending      <= (pending & ~credit) | (ghost_eaten & {4{state == ST_FRIGHT}});
      if (pw) begin
        mult_idx <= '0;
      end else if ((|pending) && (mult_idx != 2'd3)) begin
        mult_idx <= mult_idx + 2'd1;
      end
      pellets_left <= level_clear ? 8'(TOTAL_PELLETS) : pellets_nxt;
      level_clear  <= active && (pellets_left != 8'd0) && (pellets_nxt == 8'd0);

      unique case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state        <= ST_PLAY;
            score_bcd    <= '0;
            lives        <= 2'(START_LIVES);
            pellets_left <= 8'(TOTAL_PELLETS);
            level_clear  <= 1'b0;
            game_over    <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (!level_clear) begin
            if (pacman_caught) begin
              state     <= ST_DYING;
              dying_cnt <= DW'(DYING_TICKS);
              if (lives != 2'd0) begin
                lives <= lives - 2'd1;
              end
            end else if (pw) begin
              state        <= ST_FRIGHT;
              fright_cnt   <= FW'(FRIGHT_TICKS);
              frightened   <= 1'b1;
              fright_flash <= FLASH_AT_LOAD;
            end
          end
        end
        ST_FRIGHT: begin
          if (level_clear || (!pw && (fright_cnt <= FW'(1)))) begin
            state        <= ST_PLAY;
            fright_cnt   <= '0;
            frightened   <= 1'b0;
            fright_flash <= 1'b0;
          end else if (pw) begin
            fright_cnt   <= FW'(FRIGHT_TICKS);
            fright_flash <= FLASH_AT_LOAD;
          end else begin
            fright_cnt   <= fright_cnt - FW'(1);
            fright_flash <= (fright_cnt <= FW'(FLASH_TICKS + 1));
          end
        end
        ST_DYING: begin
          if (dying_cnt <= DW'(1)) begin
            dying_cnt <= '0;
            if (lives != 2'd0) begin
              state <= ST_PLAY;
            end else begin
              state     <= ST_OVER;
              game_over <= 1'b1;
            end
          end else begin
            dying_cnt <= dying_cnt - DW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: decimal-arithmetic reference model
// checked every cycle, directed scenarios with literal expectations, then
// randomized play.
module tb_score_keeper;

  localparam int TOTAL = 244;
  localparam int FT    = 360;
  localparam int FL    = 120;
  localparam int SL    = 3;
  localparam int CAP   = 999990;

  localparam int S_IDLE   = 0;
  localparam int S_PLAY   = 1;
  localparam int S_FRIGHT = 2;
  localparam int S_DYING  = 3;
  localparam int S_OVER   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pellet_eaten = 1'b0;
  logic        power_eaten = 1'b0;
  logic [3:0]  ghost_eaten = 4'd0;
  logic        pacman_caught = 1'b0;
  logic [23:0] score_bcd;
  logic        frightened;
  logic        fright_flash;
  logic [7:0]  pellets_left;
  logic [1:0]  lives;
  logic        level_clear;
  logic        game_over;

  always #5 clk = ~clk;

  score_keeper #(
    .TOTAL_PELLETS (TOTAL),
    .FRIGHT_TICKS  (FT),
    .FLASH_TICKS   (FL),
    .START_LIVES   (SL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pellet_eaten  (pellet_eaten),
    .power_eaten   (power_eaten),
    .ghost_eaten   (ghost_eaten),
    .pacman_caught (pacman_caught),
    .score_bcd     (score_bcd),
    .frightened    (frightened),
    .fright_flash  (fright_flash),
    .pellets_left  (pellets_left),
    .lives         (lives),
    .level_clear   (level_clear),
    .game_over     (game_over)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state (plain decimal integers).
  int m_st, m_score, m_lives, m_pel, m_fcnt, m_dcnt, m_mult;
  bit [3:0] m_pend;
  bit m_lc;
  int cred, add, npel;
  bit clr, act, pe, pw, lc_next;

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [23:0] ghost_seq(input int k);
    case (k)
      3:       return 24'h000050;
      4:       return 24'h000250;
      5:       return 24'h000650;
      6:       return 24'h001450;
      default: return 24'h003050;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model update: game rules applied to the inputs seen at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_st = S_IDLE; m_score = 0; m_lives = SL; m_pel = TOTAL;
      m_fcnt = 0; m_dcnt = 0; m_mult = 0; m_pend = 4'd0; m_lc = 1'b0;
    end else begin
      clr = m_lc;
      act = ((m_st == S_PLAY) || (m_st == S_FRIGHT)) && !clr;
      pe  = pellet_eaten && act;
      pw  = power_eaten && act;
      add = 10 * int'(pe) + 50 * int'(pw);
      cred = -1;
      for (int i = 0; i < 4; i++) if (cred < 0 && m_pend[i]) cred = i;
      if (cred >= 0) begin
        add = add + 200 * (1 << m_mult);
        m_pend[cred] = 1'b0;
      end
      if (m_st == S_FRIGHT) m_pend = m_pend | ghost_eaten;
      if (pw) m_mult = 0;
      else if (cred >= 0 && m_mult < 3) m_mult = m_mult + 1;
      m_score = (m_score + add > CAP) ? CAP : m_score + add;
      npel = m_pel - int'(pe) - int'(pw);
      if (npel < 0) npel = 0;
      lc_next = act && (m_pel != 0) && (npel == 0);
      m_pel = clr ? TOTAL : npel;
      m_lc = lc_next;
      case (m_st)
        S_IDLE, S_OVER: if (start) begin
          m_st = S_PLAY; m_score = 0; m_lives = SL; m_pel = TOTAL; m_lc = 1'b0;
        end
        S_PLAY: if (!clr) begin
          if (pacman_caught) begin
            m_st = S_DYING; m_dcnt = 120;
            if (m_lives > 0) m_lives = m_lives - 1;
          end else if (pw) begin
            m_st = S_FRIGHT; m_fcnt = FT;
          end
        end
        S_FRIGHT: begin
          if (clr) begin m_st = S_PLAY; m_fcnt = 0; end
          else if (pw) m_fcnt = FT;
          else if (m_fcnt == 1) begin m_st = S_PLAY; m_fcnt = 0; end
          else m_fcnt = m_fcnt - 1;
        end
        S_DYING: begin
          if (m_dcnt == 1) m_st = (m_lives > 0) ? S_PLAY : S_OVER;
          else m_dcnt = m_dcnt - 1;
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("score",        32'(score_bcd),    32'(to_bcd(m_score)));
      chk("lives",        32'(lives),        32'(m_lives));
      chk("pellets_left", 32'(pellets_left), 32'(m_pel));
      chk("frightened",   32'(frightened),   32'(m_st == S_FRIGHT));
      chk("fright_flash", 32'(fright_flash), 32'((m_st == S_FRIGHT) && (m_fcnt <= FL)));
      chk("level_clear",  32'(level_clear),  32'(m_lc));
      chk("game_over",    32'(game_over),    32'(m_st == S_OVER));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    start = 1'b0; pellet_eaten = 1'b0; power_eaten = 1'b0;
    ghost_eaten = 4'd0; pacman_caught = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int k, fr_cnt, fl_cnt, cnt, guard;

    // Reset values, then three dots.
    do_reset();
    chk("rst_score", 32'(score_bcd), 32'h0);
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_pellets", 32'(pellets_left), 32'd244);
    chk("rst_go", 32'(game_over), 32'd0);
    do_start();
    repeat (3) begin pellet_eaten = 1'b1; tick(); end
    pellet_eaten = 1'b0;
    chk("three_dots_score", 32'(score_bcd), 32'h30);
    chk("three_dots_pellets", 32'(pellets_left), 32'd241);

    // Power pellet, four ghosts at once, full frightened window.
    do_reset();
    do_start();
    power_eaten = 1'b1;
    tick();
    power_eaten = 1'b0;
    k = 2; fr_cnt = 0; fl_cnt = 0;
    while ((frightened || k <= 7) && k < 600) begin
      if (frightened) fr_cnt++;
      if (fright_flash) fl_cnt++;
      if (k >= 3 && k <= 7) chk("ghost_seq", 32'(score_bcd), 32'(ghost_seq(k)));
      ghost_eaten = (k == 2) ? 4'b1111 : 4'b0000;
      tick();
      k++;
    end
    chk("fright_cycles", 32'(fr_cnt), 32'd360);
    chk("flash_cycles", 32'(fl_cnt), 32'd120);
    chk("ghost_total", 32'(score_bcd), 32'h3050);

    // Lose all lives.
    do_reset();
    do_start();
    for (int n = 0; n < 3; n++) begin
      if (n == 2) chk("lives_before_last", 32'(lives), 32'd1);
      pacman_caught = 1'b1;
      tick();
      pacman_caught = 1'b0;
      if (n < 2) repeat (125) tick();
    end
    chk("lives_zero", 32'(lives), 32'd0);
    cnt = 0;
    while (!game_over && cnt < 300) begin cnt++; tick(); end
    chk("dying_cycles", 32'(cnt), 32'd120);
    chk("game_over_set", 32'(game_over), 32'd1);
    do_start();
    chk("restart_go", 32'(game_over), 32'd0);
    chk("restart_lives", 32'(lives), 32'd3);

    // Clear a level.
    do_reset();
    do_start();
    pellet_eaten = 1'b1;
    repeat (243) tick();
    chk("one_left", 32'(pellets_left), 32'd1);
    tick();
    pellet_eaten = 1'b0;
    chk("lc_pulse", 32'(level_clear), 32'd1);
    chk("lc_zero", 32'(pellets_left), 32'd0);
    chk("lc_score", 32'(score_bcd), 32'h2440);
    tick();
    chk("lc_drop", 32'(level_clear), 32'd0);
    chk("lc_reload", 32'(pellets_left), 32'd244);

    // Drive the score up to the cap.
    do_reset();
    do_start();
    guard = 0;
    while (m_score < 990000 && guard < 5000) begin
      ghost_eaten = 4'b1111;
      power_eaten = (m_st != S_FRIGHT);
      tick();
      guard++;
    end
    clear_inputs();
    chk("pump_reach", 32'(score_bcd >= 24'h990000), 32'd1);
    repeat (8) tick();
    guard = 0;
    while (m_score < 999980 && guard < 3000) begin
      pellet_eaten = 1'b1;
      tick();
      guard++;
    end
    pellet_eaten = 1'b0;
    chk("near_cap", 32'(score_bcd), 32'h999980);
    repeat (3) begin pellet_eaten = 1'b1; tick(); end
    pellet_eaten = 1'b0;
    chk("cap", 32'(score_bcd), 32'h999990);
    repeat (5) tick();
    chk("cap_held", 32'(score_bcd), 32'h999990);

    // Reset while frightened with ghosts still pending.
    do_reset();
    do_start();
    power_eaten = 1'b1; tick(); power_eaten = 1'b0;
    ghost_eaten = 4'b1111; tick(); ghost_eaten = 4'b0000;
    rst = 1'b1;
    tick();
    chk("midrst_score", 32'(score_bcd), 32'h0);
    chk("midrst_fright", 32'(frightened), 32'd0);
    chk("midrst_flash", 32'(fright_flash), 32'd0);
    chk("midrst_lives", 32'(lives), 32'd3);
    chk("midrst_pellets", 32'(pellets_left), 32'd244);
    chk("midrst_lc", 32'(level_clear), 32'd0);
    rst = 1'b0;
    repeat (6) tick();
    chk("midrst_no_credit", 32'(score_bcd), 32'h0);

    // Randomized play.
    do_reset();
    do_start();
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 499) == 0);
      start         = ($urandom_range(0, 99) < 2);
      pellet_eaten  = ($urandom_range(0, 99) < 40);
      power_eaten   = ($urandom_range(0, 99) < 3);
      pacman_caught = ($urandom_range(0, 99) < 2);
      for (int b = 0; b < 4; b++) ghost_eaten[b] = ($urandom_range(0, 99) < 8);
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
